// File: rtl/chart_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | chart_sequencer : frame-timed chart ROM playback with prefetch and pause  |
// | Optional feature macro: CHART_LOOP_EN (end marker restarts the chart)     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module chart_sequencer #(
  parameter int TICKS_PER_ROW = 8,
  parameter int ADDR_W        = 10
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              frame_clk,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [4:0]        rom_data,
  output logic [3:0]        display_signal,
  output logic [ADDR_W-1:0] row_count,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] TICK_RELOAD = 8'(TICKS_PER_ROW - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       frame_prev;
  logic       frame_edge;
  logic [7:0] tick_cnt;
  logic [4:0] row_buf;
  logic       start_ok;
  logic       play_step;
  logic       row_due;
  logic       emit;
  logic       end_hit;

  assign frame_edge = frame_clk & ~frame_prev;
  assign start_ok   = start & ~stop & ((state == S_IDLE) | (state == S_DONE));
  assign play_step  = (state == S_PLAY) & frame_edge & ~pause & ~stop;
  assign row_due    = play_step & (tick_cnt == 8'd0);
  assign emit       = row_due & ~row_buf[4];
  assign end_hit    = row_due & row_buf[4];

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state_next = S_FETCH;
        end
        S_FETCH: state_next = S_WAIT;
        S_WAIT:  state_next = S_PLAY;
        S_PLAY: begin
          if (emit) begin
            state_next = S_FETCH;
          end else if (end_hit) begin
`ifdef CHART_LOOP_EN
            state_next = S_FETCH;
`else
            state_next = S_DONE;
`endif
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_FETCH, S_WAIT, S_PLAY: busy = 1'b1;
      S_DONE:                  done = 1'b1;
      default:                 ;
    endcase
  end

  // The ROM strobe is high for exactly the one cycle spent in FETCH.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_prev     <= 1'b0;
      rom_rd         <= 1'b0;
      rom_addr       <= '0;
      row_count      <= '0;
      tick_cnt       <= 8'd0;
      row_buf        <= 5'd0;
      display_signal <= 4'd0;
    end else begin
      frame_prev <= frame_clk;
      rom_rd     <= (state_next == S_FETCH);

      if (state == S_WAIT) begin
        row_buf <= rom_data;
      end

      if (stop) begin
        display_signal <= 4'd0;
      end else if (frame_edge) begin
        display_signal <= emit ? row_buf[3:0] : 4'd0;
      end

      if (start_ok) begin
        rom_addr  <= '0;
        row_count <= '0;
        tick_cnt  <= TICK_RELOAD;
      end else if (emit) begin
        rom_addr  <= rom_addr + ADDR_W'(1);
        row_count <= row_count + ADDR_W'(1);
        tick_cnt  <= TICK_RELOAD;
      end else if (end_hit) begin
`ifdef CHART_LOOP_EN
        rom_addr <= '0;
        tick_cnt <= TICK_RELOAD;
`else
        tick_cnt <= tick_cnt;
`endif
      end else if (play_step) begin
        tick_cnt <= tick_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
